// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 33-cycle shift-add multiply / restoring divide feeding HI/LO.
// Ports: clk, reset (async, active-high); start/op/rs_val/rt_val request;
//   rd_req MFHI/MFLO probe; busy/done/stall/dz status; hi/lo result registers.
// Build option: define MULDIV_SIGNED_EN to build MULT/DIV (op[1] = signed).
module muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rd_req,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic        dz,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        div_q, div_d;
    logic        dvz_q, dvz_d;
    logic [31:0] opd_q, opd_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dz_q, dz_d;
    logic        done_q, done_d;

    logic [31:0] rs_mag, rt_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic        qbit;
    logic [63:0] div_step;
    logic [31:0] hi_fix, lo_fix;

`ifdef MULDIV_SIGNED_EN
    logic        rs_neg, rt_neg;
    logic        neg_res_q, neg_rem_q;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign rs_neg = op[1] & rs_val[31];
    assign rt_neg = op[1] & rt_val[31];
    assign rs_mag = rs_neg ? (32'd0 - rs_val) : rs_val;
    assign rt_mag = rt_neg ? (32'd0 - rt_val) : rt_val;

    // Remainder follows the dividend; only meaningful for divides.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            neg_res_q <= rs_neg ^ rt_neg;
            neg_rem_q <= op[0] & rs_neg;
        end
    end

    // Divide by zero keeps the all-ones quotient; the remainder fix-up
    // restores the original signed dividend in hi.
    always_comb begin
        prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
        quo_fix  = (neg_res_q & ~dvz_q) ? (32'd0 - acc_q[31:0])
                                        : acc_q[31:0];
        rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        hi_fix   = div_q ? rem_fix : prod_fix[63:32];
        lo_fix   = div_q ? quo_fix : prod_fix[31:0];
    end
`else
    logic unused_op;

    assign unused_op = op[1];
    assign rs_mag    = rs_val;
    assign rt_mag    = rt_val;
    assign hi_fix    = acc_q[63:32];
    assign lo_fix    = acc_q[31:0];
`endif

    // Multiply step: conditional add into the upper half, carry kept as
    // the bit shifted in from the top.
    assign mul_sum  = {1'b0, acc_q[63:32]}
                    + (acc_q[0] ? {1'b0, opd_q} : 33'd0);
    assign mul_step = {mul_sum, acc_q[31:1]};

    // Divide step: acc holds {remainder, remaining dividend bits}.
    assign rem_sh   = {acc_q[63:32], acc_q[31]};
    assign qbit     = (rem_sh >= {1'b0, opd_q});
    assign trial    = rem_sh - {1'b0, opd_q};
    assign div_step = {(qbit ? trial[31:0] : rem_sh[31:0]),
                       acc_q[30:0], qbit};

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == 6'd31) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy  = (state_q != S_IDLE);
        stall = rd_req & busy;
    end

    // Datapath next state
    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        dvz_d  = dvz_q;
        opd_d  = opd_q;
        acc_d  = acc_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        dz_d   = dz_q;
        done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    div_d = op[0];
                    dvz_d = op[0] & (rt_val == 32'd0);
                    cnt_d = 6'd0;
                    if (op[0]) begin
                        opd_d = rt_mag;
                        acc_d = {32'd0, rs_mag};
                    end else begin
                        opd_d = rs_mag;
                        acc_d = {32'd0, rt_mag};
                    end
                end
            end
            S_RUN: begin
                acc_d = div_q ? div_step : mul_step;
                cnt_d = cnt_q + 6'd1;
            end
            S_FIX: begin
                hi_d   = hi_fix;
                lo_d   = lo_fix;
                dz_d   = dvz_q;
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= 6'd0;
            div_q  <= 1'b0;
            dvz_q  <= 1'b0;
            opd_q  <= 32'd0;
            acc_q  <= 64'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            dvz_q  <= dvz_d;
            opd_q  <= opd_d;
            acc_q  <= acc_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            dz_q   <= dz_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed + random checks of muldiv_sequencer
// against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rd_req;
    logic        busy;
    logic        done;
    logic        stall;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    muldiv_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .rd_req (rd_req),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .dz     (dz),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural values.
    function automatic void model(input logic [1:0] o,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] h,
                                  output logic [31:0] l,
                                  output logic d);
        logic        sg;
        longint      sa, sb, q, r;
        logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
        sg = o[1];
`else
        sg = 1'b0;
`endif
        d = 1'b0;
        if (sg) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        if (!o[0]) begin
            if (sg) p = sa * sb;
            else    p = {32'd0, a} * {32'd0, b};
            h = p[63:32];
            l = p[31:0];
        end else if (b == 32'd0) begin
            d = 1'b1;
            l = 32'hFFFF_FFFF;
            h = a;
        end else begin
            q = sa / sb;
            r = sa % sb;
            l = q[31:0];
            h = r[31:0];
        end
    endfunction

    // Issue one op at a negedge; return at the negedge where done is seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int restart_at,
                          input int rd_from);
        logic [31:0] eh, el;
        logic        ed;
        int          k;
        logic        busy_ok, stall_ok;
        model(o, a, b, eh, el, ed);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start    = 1'b0;
        k        = 1;
        busy_ok  = 1'b1;
        stall_ok = 1'b1;
        while (!done && k < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (k == restart_at) begin
                start  = 1'b1;
                op     = 2'($urandom);
                rs_val = $urandom;
                rt_val = $urandom;
            end else begin
                start = 1'b0;
            end
            rd_req = (rd_from > 0) && (k >= rd_from);
            #1;
            if (stall !== rd_req) stall_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("latency", 64'(k - 1), 64'd33);
        chk("busy_during_op", 64'(busy_ok), 64'd1);
        chk("busy_after_done", 64'(busy), 64'd0);
        if (rd_from > 0) begin
            chk("stall_while_busy", 64'(stall_ok), 64'd1);
            chk("stall_at_done", 64'(stall), 64'd0);
        end
        chk("hi", 64'(hi), 64'(eh));
        chk("lo", 64'(lo), 64'(el));
        if (o[0]) chk("dz", 64'(dz), 64'(ed));
        rd_req = 1'b0;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic        done_seen;

        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'd0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        rd_req = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz", 64'(dz), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        rd_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        chk("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_max_lo", 64'(lo), 64'h1);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);

        run_op(2'b01, 32'd100, 32'd7, 0, 0);
        chk("divu_100_7_lo", 64'(lo), 64'd14);
        chk("divu_100_7_hi", 64'(hi), 64'd2);
        @(negedge clk);
        run_op(2'b01, 32'd5, 32'd0, 0, 0);
        chk("divu_dz_flag", 64'(dz), 64'd1);
        chk("divu_dz_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("divu_dz_hi", 64'(hi), 64'd5);
        @(negedge clk);

        run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 0, 0);
        @(negedge clk);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0);
        @(negedge clk);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        @(negedge clk);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd0, 0, 0);
        @(negedge clk);

        // Start mid-run is ignored, then a back-to-back start during done
        // with an MFHI reader from cycle 5.
        run_op(2'b00, 32'h1234_5678, 32'h09AB_CDEF, 10, 0);
        run_op(2'b01, 32'd1000, 32'd3, 0, 5);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, 0, 0);
            if (i % 2 == 0) @(negedge clk);
        end
        @(negedge clk);

        // Async reset in the middle of a divide.
        run_op(2'b01, 32'd9, 32'd0, 0, 0);
        @(negedge clk);
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'd200;
        rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_dz", 64'(dz), 64'd0);
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        reset = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);
        run_op(2'b00, 32'd6, 32'd7, 0, 0);
        chk("multu_6_7_lo", 64'(lo), 64'd42);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
